conv_bram_1d_result_reader: RTL and testbench

CONV_BRAM_1D_RESULT_READER -- requirements
Module: conv_bram_1d_result_reader

---
 rtl/conv_bram_1d_result_reader_if.sv | 27 ++
 rtl/conv_bram_1d_result_reader.sv | 133 +++++++++++++
 tb/tb_conv_bram_1d_result_reader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_bram_1d_result_reader_if.sv
// Handshake bundle between the 1-D conv result reader, its result RAM and the
// downstream stream consumer. master = reader side, slave = RAM/consumer side.
interface conv_bram_1d_result_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic [ADDR_WIDTH-1:0]     result_rdaddr;
  logic                      result_rden;
  logic [DATA_WIDTH*4-1:0]   result_rddata;
  logic [DATA_WIDTH*4-1:0]   out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;

  modport master (
    input  start, result_rddata, out_ready,
    output busy, done, result_rdaddr, result_rden, out_data, out_valid, out_last
  );

  modport slave (
    output start, result_rddata, out_ready,
    input  busy, done, result_rdaddr, result_rden, out_data, out_valid, out_last
  );
endinterface

// File: rtl/conv_bram_1d_result_reader.sv
// Drains the 1-D conv result RAM in address order and streams each entry out
// through a 2-entry skid FIFO, flagging the final entry with out_last.
module conv_bram_1d_result_reader #(
  parameter int DATA_WIDTH            = 8,
  parameter int IMG_W                 = 32,
  parameter int FILTER_L              = 3,
  parameter int STRIDE_W              = 1,
  parameter int RESULT_W              = (IMG_W - FILTER_L) / STRIDE_W + 1,
  parameter int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W)
) (
  input  logic                          clk,
  input  logic                          reset,
  conv_bram_1d_result_reader_if.master  bus_if
);

  localparam int DW    = DATA_WIDTH * 4;
  localparam int CNT_W = $clog2(RESULT_W + 1);
  localparam logic [CNT_W-1:0] NUM_ENTRIES = CNT_W'(RESULT_W);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(RESULT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              busy_q;
  logic              done_q;

  logic [CNT_W-1:0]  issued_q, issued_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;

  logic [DW-1:0]     fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              out_valid;
  logic              out_last;
  logic              push;
  logic              pop;
  logic              rden;
  logic [2:0]        occupancy;

  // Read issue is gated on FIFO slots not yet claimed by stored or in-flight
  // entries; a pop in the same cycle frees a slot early.
  always_comb begin
    out_valid       = (count_q != 2'd0);
    out_last        = out_valid & fifo_last_q[rd_ptr_q];
    pop             = out_valid & bus_if.out_ready;
    push            = inflight_q;
    occupancy       = {1'b0, count_q} + {2'b00, inflight_q};
    rden            = (state_q == RUN) && (issued_q < NUM_ENTRIES) &&
                      (occupancy < (3'd2 + {2'b00, pop}));
    issued_d        = (state_q == RUN) ? issued_q + CNT_W'(rden) : '0;
    inflight_d      = rden;
    inflight_last_d = rden && (issued_q == LAST_IDX);
    count_d         = count_q + 2'(push) - 2'(pop);
    wr_ptr_d        = wr_ptr_q ^ push;
    rd_ptr_d        = rd_ptr_q ^ pop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus_if.start) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: if (pop && out_last) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      count_q         <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
    end else begin
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
    end
  end

  // RAM data lands one cycle after rden; capture it into the slot at wr_ptr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= 2'b00;
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= bus_if.result_rddata;
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

  assign bus_if.busy          = busy_q;
  assign bus_if.done          = done_q;
  assign bus_if.result_rden   = rden;
  assign bus_if.result_rdaddr = rden ? issued_q[RESULT_RAM_ADDR_WIDTH-1:0] : '0;
  assign bus_if.out_data      = fifo_data_q[rd_ptr_q];
  assign bus_if.out_valid     = out_valid;
  assign bus_if.out_last      = out_last;

endmodule

// File: tb/tb_conv_bram_1d_result_reader.sv
// Scoreboard bench for conv_bram_1d_result_reader: stimulus queues expected
// stream entries, a negedge monitor checks handshakes, reads and done pulses.
module tb_conv_bram_1d_result_reader;

  localparam int DW       = 8;
  localparam int RESULT_W = 30;
  localparam int AW       = 5;

  typedef struct {
    logic [DW*4-1:0] data;
    logic            last;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;

  logic [DW*4-1:0] mem [0:31];
  exp_t            exp_q [$];

  int n_checks;
  int n_fail;
  int done_cnt;
  int rd_total;
  int xfer_cnt;
  int start_cyc;
  int first_xfer_cyc;
  int last_xfer_cyc;
  int done_cyc;

  conv_bram_1d_result_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  conv_bram_1d_result_reader #(
    .DATA_WIDTH(DW), .IMG_W(32), .FILTER_L(3), .STRIDE_W(1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous result RAM: data valid the cycle after rden.
  always @(posedge clk) begin
    if (bus.result_rden) bus.result_rddata <= mem[bus.result_rdaddr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic queue_run();
    exp_t e;
    for (int i = 0; i < RESULT_W; i++) begin
      e.data = 32'(i + 100);
      e.last = (i == RESULT_W - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    step();
    bus.start      = 1'b1;
    start_cyc      = cyc;
    first_xfer_cyc = -1;
    step();
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= target) break;
    end
    check("done_count", 64'(done_cnt), 64'(target));
  endtask

  // Monitor: read-address order, credit rule, stall stability, scoreboard, done.
  initial begin : monitor
    int          m_cnt;
    int          m_infl;
    int          next_addr;
    bit          last_prev;
    bit          hold_vld;
    logic [31:0] hold_data;
    logic        hold_last;
    bit          pop;
    exp_t        e;
    m_cnt = 0; m_infl = 0; next_addr = 0; last_prev = 0; hold_vld = 0;
    hold_data = '0; hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_cnt = 0; m_infl = 0; next_addr = 0; last_prev = 0; hold_vld = 0;
        continue;
      end
      pop = bus.out_valid && bus.out_ready;
      if (bus.done || last_prev) check("done_pulse", 64'(bus.done), 64'(last_prev));
      if (bus.done) begin
        done_cnt++;
        done_cyc  = cyc;
        next_addr = 0;
      end
      last_prev = 0;
      if (bus.result_rden) begin
        rd_total++;
        check("rd_in_range", 64'(next_addr < RESULT_W), 64'd1);
        check("rd_addr", 64'(bus.result_rdaddr), 64'(next_addr));
        check("rd_credit", 64'((m_cnt + m_infl - int'(pop)) < 2), 64'd1);
        next_addr++;
      end else if (bus.result_rdaddr != '0) begin
        check("rdaddr_idle", 64'(bus.result_rdaddr), 64'd0);
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (hold_vld) begin
          check("hold_data", 64'(bus.out_data), 64'(hold_data));
          check("hold_last", 64'(bus.out_last), 64'(hold_last));
        end
        hold_vld  = 1;
        hold_data = bus.out_data;
        hold_last = bus.out_last;
      end else begin
        hold_vld = 0;
      end
      if (pop) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 64'(bus.out_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(bus.out_data), 64'(e.data));
          check("out_last", 64'(bus.out_last), 64'(e.last));
          last_prev = e.last;
        end
        xfer_cnt++;
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
      end
      m_cnt  = m_cnt + m_infl - int'(pop);
      m_infl = int'(bus.result_rden);
    end
  end

  initial begin : stimulus
    int base;
    n_checks = 0; n_fail = 0; done_cnt = 0; rd_total = 0; xfer_cnt = 0;
    start_cyc = 0; first_xfer_cyc = -1; last_xfer_cyc = 0; done_cyc = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i + 100);
    reset = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_rden", 64'(bus.result_rden), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    reset = 1'b1;

    // Full-throughput drain with timing checks.
    bus.out_ready = 1'b1;
    queue_run();
    pulse_start();
    check("busy_run", 64'(bus.busy), 64'd1);
    wait_done(1, 80);
    check("first_xfer_latency", 64'(first_xfer_cyc - start_cyc), 64'd3);
    check("back_to_back", 64'(last_xfer_cyc - first_xfer_cyc), 64'd29);
    check("start_to_done", 64'(done_cyc - start_cyc), 64'(RESULT_W + 3));
    step();
    check("idle_after_done", 64'(bus.busy), 64'd0);
    check("q_empty_1", 64'(exp_q.size()), 64'd0);

    // Downstream stalled for 10 cycles after start.
    bus.out_ready = 1'b0;
    queue_run();
    base = rd_total;
    pulse_start();
    repeat (9) step();
    check("stall_reads", 64'(rd_total - base), 64'd2);
    check("stall_valid", 64'(bus.out_valid), 64'd1);
    check("stall_data", 64'(bus.out_data), 64'd100);
    bus.out_ready = 1'b1;
    wait_done(2, 80);
    check("q_empty_2", 64'(exp_q.size()), 64'd0);

    // Pseudo-random backpressure.
    queue_run();
    pulse_start();
    for (int i = 0; i < 400 && done_cnt < 3; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.out_ready = 1'b1;
    wait_done(3, 10);
    check("q_empty_3", 64'(exp_q.size()), 64'd0);

    // start held high: two back-to-back runs, dropped during the second DONE.
    step();
    queue_run();
    queue_run();
    bus.start = 1'b1;
    wait_done(4, 100);
    check("q_after_run4", 64'(exp_q.size()), 64'(RESULT_W));
    wait_done(5, 100);
    bus.start = 1'b0;
    repeat (3) step();
    check("held_start_idle", 64'(bus.busy), 64'd0);
    check("q_empty_5", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset after the 12th transfer of a run.
    queue_run();
    base = xfer_cnt;
    pulse_start();
    for (int i = 0; i < 60 && (xfer_cnt - base) < 12; i++) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_xfers", 64'(xfer_cnt - base), 64'd12);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_rden", 64'(bus.result_rden), 64'd0);
    check("arst_addr", 64'(bus.result_rdaddr), 64'd0);
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_last", 64'(bus.out_last), 64'd0);
    check("arst_data", 64'(bus.out_data), 64'd0);
    exp_q.delete();
    repeat (2) step();
    queue_run();
    reset = 1'b1;
    bus.start = 1'b1;
    start_cyc = cyc;
    first_xfer_cyc = -1;
    step();
    bus.start = 1'b0;
    wait_done(6, 80);
    check("post_rst_latency", 64'(first_xfer_cyc - start_cyc), 64'd3);
    check("q_empty_6", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
